// File: rtl/s2_cfg_pkg.sv
// Shared types and constants for the S2 serial configuration loader.
package s2_cfg_pkg;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CSUM,
    COMMIT
  } state_e;

  localparam int unsigned HDR_W       = 8;
  localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
  localparam int unsigned CSUM_W      = 4;

endpackage

// File: rtl/s2_cfg_if.sv
// Serial configuration bit stream with a valid/ready handshake.
interface s2_cfg_if;
  logic din;
  logic din_valid;
  logic din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/s2_hdr_hunter.sv
// Sliding 8-bit header window; match flags the edge that completes the header.
module s2_hdr_hunter
  import s2_cfg_pkg::*;
#(
  parameter logic [HDR_W-1:0] HDR = HDR_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  logic [HDR_W-1:0] win_q;
  logic [HDR_W-1:0] win_d;
  logic [HDR_W-1:0] win_next;

  always_comb begin
    win_next = {win_q[HDR_W-2:0], bit_in};
    win_d    = win_q;
    if (clear) begin
      win_d = '0;
    end else if (shift_en) begin
      win_d = win_next;
    end
  end

  // Compare includes the bit being accepted so the lock happens on that edge.
  assign match = shift_en && (win_next == HDR);

  always_ff @(posedge clk) begin
    if (clr) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/s2_cfg_loader.sv
// Serial frame loader: header hunt, payload shift, XOR checksum, atomic commit to cfg.
module s2_cfg_loader
  import s2_cfg_pkg::*;
#(
  parameter int unsigned      NCELLS = 4,
  parameter logic [HDR_W-1:0] HDR    = HDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  clr,
  s2_cfg_if.slave               ser,
  output logic [4*NCELLS-1:0]   cfg,
  output logic                  cfg_ld,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned PW = 4 * NCELLS;
  localparam int unsigned CW = $clog2(PW);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       shadow_q, shadow_d;
  logic [CSUM_W-1:0]   acc_q, acc_d;
  logic [CSUM_W-1:0]   rx_q, rx_d;
  logic [PW-1:0]       cfg_q, cfg_d;
  logic                cfg_ld_q, cfg_ld_d;
  logic                err_q, err_d;

  logic                accept;
  logic                hdr_match;
  logic [1:0]          nib_pos;

  assign ser.din_ready = (state_q != COMMIT);
  assign accept        = ser.din_valid && ser.din_ready;

  s2_hdr_hunter #(
    .HDR (HDR)
  ) u_hunter (
    .clk      (clk),
    .clr      (clr),
    .clear    (state_q == COMMIT),
    .shift_en (accept && (state_q == HUNT)),
    .bit_in   (ser.din),
    .match    (hdr_match)
  );

  // Payload bit k of a nibble arrives MSB first, so its checksum position is 3-k.
  assign nib_pos = ~cnt_q[1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    rx_d     = rx_q;
    cfg_d    = cfg_q;
    cfg_ld_d = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      HUNT: begin
        if (accept && hdr_match) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          shadow_d         = {shadow_q[PW-2:0], ser.din};
          acc_d[nib_pos]   = acc_q[nib_pos] ^ ser.din;
          if (cnt_q == CW'(PW - 1)) begin
            state_d = CSUM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          rx_d = {rx_q[CSUM_W-2:0], ser.din};
          if (cnt_q == CW'(CSUM_W - 1)) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = HUNT;
        if (rx_q == acc_q) begin
          cfg_d    = shadow_q;
          cfg_ld_d = 1'b1;
          err_d    = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      shadow_q <= '0;
      acc_q    <= '0;
      rx_q     <= '0;
      cfg_q    <= '0;
      cfg_ld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      rx_q     <= rx_d;
      cfg_q    <= cfg_d;
      cfg_ld_q <= cfg_ld_d;
      err_q    <= err_d;
    end
  end

  assign cfg    = cfg_q;
  assign cfg_ld = cfg_ld_q;
  assign err    = err_q;
  assign busy   = (state_q != HUNT);

endmodule

// File: tb/tb_s2_cfg_loader.sv
// Directed bench for s2_cfg_loader with NCELLS=4, header A5.
module tb_s2_cfg_loader;

  logic        clk;
  logic        clr;
  logic [15:0] cfg;
  logic        cfg_ld;
  logic        busy;
  logic        err;

  s2_cfg_if sif ();

  s2_cfg_loader #(
    .NCELLS (4),
    .HDR    (8'hA5)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .ser    (sif.slave),
    .cfg    (cfg),
    .cfg_ld (cfg_ld),
    .busy   (busy),
    .err    (err)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned ld_cnt   = 0;
  int unsigned ld_acc   = 0;
  logic [15:0] ld_cfg[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_ld) begin
      ld_cnt++;
      ld_cfg.push_back(cfg);
      if (sif.din_valid && sif.din_ready) ld_acc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic b, input int unsigned gap);
    logic        took;
    int unsigned n;
    if (gap > 0) begin
      sif.din_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    sif.din       = b;
    sif.din_valid = 1'b1;
    took = 1'b0;
    n    = 0;
    while (!took && n < 20) begin
      took = sif.din_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] pay,
                            input logic [3:0] cs, input logic gaps);
    for (int i = 7; i >= 0; i--)  send_bit(hdr[i], gaps ? $urandom_range(0, 2) : 0);
    for (int i = 15; i >= 0; i--) send_bit(pay[i], gaps ? $urandom_range(0, 2) : 0);
    for (int i = 3; i >= 0; i--)  send_bit(cs[i],  gaps ? $urandom_range(0, 2) : 0);
  endtask

  task automatic settle();
    sif.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int unsigned ld0;
  int unsigned acc0;
  logic [15:0] part;

  initial begin
    clr           = 1'b1;
    sif.din       = 1'b0;
    sif.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cfg", 32'(cfg), 32'h0);
    check("rst_cfg_ld", 32'(cfg_ld), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(sif.din_ready), 32'h1);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Good frame, latency of cfg_ld relative to the last checksum bit
    send_frame(8'hA5, 16'h1234, 4'h4, 1'b0);
    check("t1_commit_ld", 32'(cfg_ld), 32'h0);
    check("t1_commit_ready", 32'(sif.din_ready), 32'h0);
    check("t1_commit_busy", 32'(busy), 32'h1);
    sif.din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t1_ld", 32'(cfg_ld), 32'h1);
    check("t1_cfg", 32'(cfg), 32'h1234);
    check("t1_err", 32'(err), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check("t1_ld_drop", 32'(cfg_ld), 32'h0);

    // Bad checksums hold cfg and set err; good frame clears it
    ld0 = ld_cnt;
    send_frame(8'hA5, 16'h1234, 4'h5, 1'b0);
    settle();
    check("t2_err", 32'(err), 32'h1);
    check("t2_cfg_hold", 32'(cfg), 32'h1234);
    check("t2_no_ld", ld_cnt, ld0);
    send_frame(8'hA5, 16'hBEEF, 4'hE, 1'b0);
    settle();
    check("t2_beef_e_err", 32'(err), 32'h1);
    check("t2_beef_e_cfg", 32'(cfg), 32'h1234);
    send_frame(8'hA5, 16'hBEEF, 4'h4, 1'b0);
    settle();
    check("t2_good_cfg", 32'(cfg), 32'hBEEF);
    check("t2_good_err", 32'(err), 32'h0);
    check("t2_ld_cnt", ld_cnt, ld0 + 1);

    // Noise before the header
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    send_bit(1'b1, 0); send_bit(1'b0, 0);
    check("t3_noise_busy", 32'(busy), 32'h0);
    send_frame(8'hA5, 16'h00F0, 4'hF, 1'b0);
    settle();
    check("t3_cfg", 32'(cfg), 32'h00F0);
    check("t3_err", 32'(err), 32'h0);

    // Valid gaps and valid held high through COMMIT
    ld0 = ld_cnt;
    send_frame(8'hA5, 16'h1234, 4'h4, 1'b1);
    check("t4_commit_ready", 32'(sif.din_ready), 32'h0);
    send_bit(1'b0, 0);
    sif.din_valid = 1'b0;
    settle();
    check("t4_cfg", 32'(cfg), 32'h1234);
    check("t4_err", 32'(err), 32'h0);
    check("t4_ld_cnt", ld_cnt, ld0 + 1);

    // Header pattern inside the payload is plain data
    send_frame(8'hA5, 16'hA5A5, 4'h0, 1'b0);
    settle();
    check("t5_cfg", 32'(cfg), 32'hA5A5);
    check("t5_err", 32'(err), 32'h0);

    // clr mid-payload discards the frame
    ld0 = ld_cnt;
    part = 16'h1234;
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hA5 >> i), 0);
    for (int i = 15; i >= 9; i--) send_bit(part[i], 0);
    check("t6_busy_pre", 32'(busy), 32'h1);
    sif.din_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("t6_cfg_clr", 32'(cfg), 32'h0);
    check("t6_busy_clr", 32'(busy), 32'h0);
    check("t6_ld_clr", 32'(cfg_ld), 32'h0);
    send_frame(8'hA5, 16'h5A3C, 4'h0, 1'b0);
    settle();
    check("t6_cfg", 32'(cfg), 32'h5A3C);
    check("t6_ld_cnt", ld_cnt, ld0 + 1);

    // Back-to-back frames
    ld0  = ld_cnt;
    acc0 = ld_acc;
    send_frame(8'hA5, 16'hC0DE, 4'hF, 1'b0);
    send_frame(8'hA5, 16'h0123, 4'h0, 1'b0);
    settle();
    check("t7_ld_cnt", ld_cnt, ld0 + 2);
    check("t7_b2b_accept", ld_acc, acc0 + 1);
    if (ld_cfg.size() >= 2) begin
      check("t7_first_cfg", 32'(ld_cfg[ld_cfg.size()-2]), 32'hC0DE);
      check("t7_second_cfg", 32'(ld_cfg[ld_cfg.size()-1]), 32'h0123);
    end else begin
      check("t7_pulses", ld_cfg.size(), 2);
    end
    check("t7_cfg", 32'(cfg), 32'h0123);
    check("t7_err", 32'(err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
